// File: rtl/baud_gen_pkg.sv
// baud_gen_pkg: shared constants and types for the
// fractional baud generator.
package baud_gen_pkg;

  localparam int DFLT_DIV_INT_W  = 12;
  localparam int DFLT_FRAC_W     = 8;
  localparam int DFLT_OVERSAMPLE = 16;
  localparam int DFLT_RST_INT    = 78;
  localparam int DFLT_RST_FRAC   = 32;

  localparam int OS_W = $clog2(DFLT_OVERSAMPLE);

  typedef struct packed {
    logic [DFLT_DIV_INT_W-1:0] ip;
    logic [DFLT_FRAC_W-1:0]    fp;
  } baud_div_t;

  function automatic int os_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_frac_cnt.sv
// baud_frac_cnt: fractional period counter with
// active/shadow divisor; issues the oversample tick.
module baud_frac_cnt
  import baud_gen_pkg::*;
#(
  parameter int DIV_INT_W    = DFLT_DIV_INT_W,
  parameter int FRAC_W       = DFLT_FRAC_W,
  parameter int RST_DIV_INT  = DFLT_RST_INT,
  parameter int RST_DIV_FRAC = DFLT_RST_FRAC
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 restart_i,
  input  logic                 div_wr_i,
  input  logic [DIV_INT_W-1:0] div_int_i,
  input  logic [FRAC_W-1:0]    div_frac_i,
  output logic                 pending_o,
  output logic                 tick_o,
  output logic                 evt_o,
  output logic                 rst_evt_o,
  output logic                 halt_o
);

  localparam int CW = DIV_INT_W + 1;

  typedef struct packed {
    logic [DIV_INT_W-1:0] ip;
    logic [FRAC_W-1:0]    fp;
  } div_t;

  div_t              act_q, act_d;
  div_t              shd_q, shd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic              pend_q, pend_d;
  logic              tick_q, tick_d;

  logic [CW-1:0]     per;
  logic [FRAC_W:0]   sum;
  logic              rst_evt;
  logic              halt;
  logic              last;

  assign per     = {1'b0, act_q.ip} + CW'(extra_q);
  assign sum     = {1'b0, acc_q} + {1'b0, act_q.fp};
  assign rst_evt = en_i & restart_i;
  assign halt    = (act_q.ip == '0);
  assign last    = (cnt_q == per - CW'(1));

  assign evt_o     = en_i & ~restart_i & ~halt & last;
  assign rst_evt_o = rst_evt;
  assign halt_o    = halt;
  assign pending_o = pend_q;
  assign tick_o    = tick_q;

  // next state: restart beats period end; writes always land in shadow
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    extra_d = extra_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    if (rst_evt) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (en_i) begin
      if (halt) begin
        cnt_d = '0;
      end else if (last) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        acc_d   = sum[FRAC_W-1:0];
        extra_d = sum[FRAC_W];
        if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (div_wr_i) begin
      shd_d.ip = div_int_i;
      shd_d.fp = div_frac_i;
      pend_d   = 1'b1;
    end
  end

  // state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      extra_q  <= 1'b0;
      act_q.ip <= DIV_INT_W'(RST_DIV_INT);
      act_q.fp <= FRAC_W'(RST_DIV_FRAC);
      shd_q.ip <= DIV_INT_W'(RST_DIV_INT);
      shd_q.fp <= FRAC_W'(RST_DIV_FRAC);
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      extra_q <= extra_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional UART baud generator with
// oversample tick, baud tick and square-wave output.
module baud_gen_frac
  import baud_gen_pkg::*;
#(
  parameter int DIV_INT_W    = DFLT_DIV_INT_W,
  parameter int FRAC_W       = DFLT_FRAC_W,
  parameter int OVERSAMPLE   = DFLT_OVERSAMPLE,
  parameter int RST_DIV_INT  = DFLT_RST_INT,
  parameter int RST_DIV_FRAC = DFLT_RST_FRAC
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 restart,
  input  logic                 div_wr,
  input  logic [DIV_INT_W-1:0] div_int,
  input  logic [FRAC_W-1:0]    div_frac,
  output logic                 div_pending,
  output logic                 tick_os,
  output logic                 tick_baud,
  output logic                 clk_out
);

  localparam int OSW = os_bits(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);

  logic [OSW-1:0] os_q, os_d;
  logic           baud_q, baud_d;
  logic           clk_q, clk_d;
  logic           evt;
  logic           rst_evt;
  logic           halt;

  baud_frac_cnt #(
    .DIV_INT_W   (DIV_INT_W),
    .FRAC_W      (FRAC_W),
    .RST_DIV_INT (RST_DIV_INT),
    .RST_DIV_FRAC(RST_DIV_FRAC)
  ) u_cnt (
    .clk_i     (clk_in),
    .rst_ni    (rst_n),
    .en_i      (en),
    .restart_i (restart),
    .div_wr_i  (div_wr),
    .div_int_i (div_int),
    .div_frac_i(div_frac),
    .pending_o (div_pending),
    .tick_o    (tick_os),
    .evt_o     (evt),
    .rst_evt_o (rst_evt),
    .halt_o    (halt)
  );

  assign tick_baud = baud_q;
  assign clk_out   = clk_q;

  // oversample count, baud strobe and half-period toggles
  always_comb begin
    os_d   = os_q;
    baud_d = 1'b0;
    clk_d  = clk_q;
    if (rst_evt) begin
      os_d  = '0;
      clk_d = 1'b0;
    end else if (en && halt) begin
      os_d = '0;
    end else if (evt) begin
      baud_d = (os_q == OS_LAST);
      os_d   = (os_q == OS_LAST) ? '0 : os_q + OSW'(1);
      if (os_q == OS_HALF || os_q == OS_LAST) begin
        clk_d = ~clk_q;
      end
    end
  end

  // output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      os_q   <= '0;
      baud_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      os_q   <= os_d;
      baud_q <= baud_d;
      clk_q  <= clk_d;
    end
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised successor to the fixed integer UART clock dividers.
- Generates three outputs from clk_in:
  - an oversample strobe, from a runtime-programmable fractional divisor;
  - a baud strobe, once per OVERSAMPLE oversample strobes;
  - a 50%-duty baud-rate square wave.
- Feeds uart_tx/uart_rx bit timing.
- Supports enable, phase restart and glitch-free divisor update at period boundaries.

Parameters:
- DIV_INT_W, 12: width of the integer divisor part.
- FRAC_W, 8: width of the fractional divisor part and the phase accumulator.
- OVERSAMPLE, 16: oversample strobes per baud period. Must be even and >=2.
- RST_DIV_INT, 78: integer divisor after reset (12 MHz / (16 x 9600) = 78.125).
- RST_DIV_FRAC, 32: fractional divisor after reset (0.125 x 256).

Ports:
- clk_in, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: count enable. When low, all state holds and no strobes are issued.
- restart, input, 1: synchronous phase realign. Only acted on when en=1.
- div_wr, input, 1: single-cycle write strobe that loads the shadow divisor.
- div_int, input, DIV_INT_W: integer divisor; oversample period in clk_in cycles.
- div_frac, input, FRAC_W: fractional divisor in units of 1/2^FRAC_W cycle.
- div_pending, output, 1: shadow divisor written but not yet active.
- tick_os, output, 1: one-cycle oversample strobe.
- tick_baud, output, 1: one-cycle baud strobe, coincident with a tick_os.
- clk_out, output, 1: square wave at the baud rate.

Behaviour:
- Reset (rst_n=0, asynchronous), all values:
  - cnt=0, acc=0, extra=0, os_cnt=0.
  - Active and shadow divisors = RST_DIV_INT/RST_DIV_FRAC.
  - div_pending=0, tick_os=0, tick_baud=0, clk_out=0.
- Period length: P = act_int + extra.
  - cnt increments on each enabled edge.
  - On the edge where cnt==P-1: cnt<=0, and registered tick_os is high for the following cycle.
  - The first tick_os follows the act_int-th enabled edge after reset release.
- Fractional accumulation, at each tick_os event: {carry, acc} <= acc + act_frac; extra <= carry. The next period is therefore act_int+1 cycles whenever carry=1.
- Oversample count, at each tick_os event: os_cnt increments modulo OVERSAMPLE.
  - tick_baud is asserted with the tick_os event where os_cnt==OVERSAMPLE-1.
  - clk_out toggles on tick_os events where os_cnt==OVERSAMPLE/2-1 or os_cnt==OVERSAMPLE-1.
- Divisor update:
  - div_wr captures div_int/div_frac into the shadow register and sets div_pending=1.
  - The shadow is copied into the active divisor at the next tick_os event or at restart. div_pending clears at that copy.
  - The period in progress is never altered.
- div_wr in the same cycle as a boundary: the old shadow is applied and the new value is captured; div_pending stays 1 and the new value applies at the following boundary.
- restart with en=1:
  - Clears cnt, acc, extra, os_cnt and clk_out; no tick is issued that cycle.
  - Applies the shadow only if div_pending was already 1.
  - restart has priority over a coinciding period end.
- en=0: everything holds, tick outputs are 0, clk_out holds its level. Ticks resume exactly where counting stopped.
- act_int==0 (halted): no tick_os is issued; cnt and os_cnt are held at 0. A pending shadow is still applied on restart.
- act_int==1 with act_frac==0: tick_os is high every cycle; this is legal.
- Widths: cnt is DIV_INT_W+1 bits, so P=2^DIV_INT_W is reachable. All arithmetic is unsigned and wraps only where stated above.
- No combinational path from inputs to outputs.

Decomposition:
- Package baud_gen_pkg holds:
  - OS_W = clog2(OVERSAMPLE);
  - the reset divisor constants;
  - the divisor struct typedef {int, frac}.
- One sub-module, baud_frac_cnt, contains cnt/acc/extra plus the active/shadow divisor and produces tick_os.
- The top level adds os_cnt, tick_baud and clk_out.

Test Plan:
- Reset release, en=1, defaults 78/32 -> tick_os periods: eight of 78 cycles, then one of 79, repeating. tick_baud every 16 tick_os (1250 cycles average). clk_out period 1250 cycles average, high phase 8 tick_os.
- div_wr of int=6, frac=0 mid-period -> div_pending=1 until the next tick_os; the current period remains 78/79 cycles; subsequent periods are exactly 6 cycles; tick_baud every 96 cycles.
- restart pulsed at os_cnt=5 -> next tick_os exactly act_int cycles later; clk_out low; tick_baud after a further 16 tick_os.
- en low for 40 cycles mid-period -> no ticks during the gap; the period completes with its remaining cycle count after en returns.
- div_wr int=0 then restart -> no tick_os for 1000 cycles. div_wr int=4 plus restart -> tick_os every 4 cycles.
- rst_n asserted asynchronously mid-period with divisor 6/0 -> all outputs 0 immediately; divisor returns to 78/32.
